// File: rtl/write_iq.sv
// write_iq: dequantizes paired I/Q samples from two FWFT FIFOs and serializes them
// onto a byte FIFO as I_lo, I_hi, Q_lo, Q_hi (little-endian, two's complement).
module write_iq #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] I_dout,
    input  logic                  I_empty,
    output logic                  I_rd_en,
    input  logic [DATA_WIDTH-1:0] Q_dout,
    input  logic                  Q_empty,
    output logic                  Q_rd_en,
    output logic [7:0]            out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [15:0]           sat_count
);
    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;
    localparam logic signed [DATA_WIDTH-1:0] S_MAX = DATA_WIDTH'(32767);
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = DATA_WIDTH'(-32768);
    state_t state, state_nx;
    logic [15:0] i_reg, q_reg, i_sat, q_sat;
    logic i_clip, q_clip, pop;
    logic [16:0] sat_sum;

    // Returns {clamped, value}: floor shift, then clamp to signed 16 bit.
    function automatic logic [16:0] sat16(input logic [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] s;
        s = $signed(x) >>> BITS;
        return s > S_MAX ? {1'b1, 16'h7FFF} : s < S_MIN ? {1'b1, 16'h8000} : {1'b0, s[15:0]};
    endfunction

    assign {i_clip, i_sat} = sat16(I_dout);
    assign {q_clip, q_sat} = sat16(Q_dout);
    assign I_rd_en = pop;
    assign Q_rd_en = pop;
    assign sat_sum = {1'b0, sat_count} + 17'(i_clip) + 17'(q_clip);

    always_comb begin
        out_wr_en = state != S_IDLE && !out_full;
        out_din   = state == S_B0 ? i_reg[7:0] : state == S_B1 ? i_reg[15:8] :
                    state == S_B2 ? q_reg[7:0] : state == S_B3 ? q_reg[15:8] : 8'h00;
        // Pops are gated by reset so nothing is consumed while the block is held in reset.
        pop       = reset && !I_empty && !Q_empty && (state == S_IDLE || (state == S_B3 && !out_full));
        state_nx  = pop ? S_B0 : (state == S_IDLE || !out_wr_en) ? state :
                    state == S_B3 ? S_IDLE : state_t'(state + 3'd1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            i_reg     <= '0;
            q_reg     <= '0;
            sat_count <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                i_reg     <= i_sat;
                q_reg     <= q_sat;
                sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end
endmodule

// File: tb/tb_write_iq.sv
// tb_write_iq: randomized and directed checks of write_iq against a queue-based byte model.
module tb_write_iq;
    logic        clock = 0, reset = 0;
    logic [31:0] I_dout = 0, Q_dout = 0;
    logic        I_empty = 1, Q_empty = 1, out_full = 0;
    logic        I_rd_en, Q_rd_en, out_wr_en;
    logic [7:0]  out_din;
    logic [15:0] sat_count;

    write_iq #(.DATA_WIDTH(32), .BITS(10)) dut (
        .clock(clock), .reset(reset),
        .I_dout(I_dout), .I_empty(I_empty), .I_rd_en(I_rd_en),
        .Q_dout(Q_dout), .Q_empty(Q_empty), .Q_rd_en(Q_rd_en),
        .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
        .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    logic [31:0] iq[$], qq[$];
    logic [7:0]  exp_b[$];
    int exp_sat = 0, tests = 0, fails = 0;
    int cyc = 0, n_wr = 0, n_pop = 0, first_pop = 0, last_wr = 0, last_pop = 0, gap_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Dequantize by floor division with 2^10, then clamp; returns {clamped, value}.
    function automatic logic [16:0] model(input logic [31:0] x);
        longint v, q;
        v = longint'($signed(x));
        q = v >= 0 ? v / 1024 : -((-v + 1023) / 1024);
        if (q > 32767) return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    task automatic clr();
        n_wr = 0; n_pop = 0; gap_bad = 0;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] q);
        iq.push_back(i);
        qq.push_back(q);
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic step();
        logic rd, wr, exp_wr, exp_rd;
        logic [7:0] din, b;
        logic [16:0] mi, mq;
        I_empty = iq.size() == 0;
        Q_empty = qq.size() == 0;
        I_dout  = I_empty ? 32'h0 : iq[0];
        Q_dout  = Q_empty ? 32'h0 : qq[0];
        #1;
        rd = I_rd_en; wr = out_wr_en; din = out_din;
        chk("rd_pair", 32'(Q_rd_en), 32'(rd));
        exp_wr = reset && exp_b.size() > 0 && !out_full;
        chk("wr_en", 32'(wr), 32'(exp_wr));
        exp_rd = reset && iq.size() > 0 && qq.size() > 0 &&
                 (exp_b.size() == 0 || (exp_b.size() == 1 && exp_wr));
        chk("rd_en", 32'(rd), 32'(exp_rd));
        if (wr && exp_b.size() > 0) begin
            b = exp_b.pop_front();
            chk("byte", 32'(din), 32'(b));
            n_wr++;
            last_wr = cyc;
        end
        if (rd && iq.size() > 0 && qq.size() > 0) begin
            mi = model(iq.pop_front());
            mq = model(qq.pop_front());
            exp_b.push_back(mi[7:0]);
            exp_b.push_back(mi[15:8]);
            exp_b.push_back(mq[7:0]);
            exp_b.push_back(mq[15:8]);
            exp_sat = exp_sat + int'(mi[16]) + int'(mq[16]);
            if (exp_sat > 65535) exp_sat = 65535;
            if (n_pop == 0) first_pop = cyc;
            else if (cyc - last_pop != 4) gap_bad++;
            n_pop++;
            last_pop = cyc;
        end
        @(posedge clock);
        #1;
        chk("sat_count", 32'(sat_count), 32'(exp_sat));
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_b.size() > 0 || (iq.size() > 0 && qq.size() > 0)) && k < 300) begin
            step();
            k++;
        end
        chk("drain_timeout", 32'(k < 300), 32'd1);
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (n_wr < n && k < 50) begin
            step();
            k++;
        end
        chk("wait_wr_timeout", 32'(k < 50), 32'd1);
    endtask

    initial begin
        @(negedge clock);
        #1;
        chk("rst_wr", 32'(out_wr_en), 0);
        chk("rst_din", 32'(out_din), 0);
        chk("rst_rd", 32'(I_rd_en), 0);
        chk("rst_sat", 32'(sat_count), 0);
        @(negedge clock);
        reset = 1;
        step();

        // single pair with exact timing
        clr();
        push(32'h0001_2C00, 32'hFFFF_FC00);
        drain();
        chk("t1_nwr", n_wr, 4);
        chk("t1_span", last_wr - first_pop, 4);

        // saturation both ways
        push(32'h7FFF_FFFF, 32'h8000_0000);
        drain();
        chk("t2_sat", 32'(sat_count), 2);

        // back-pressure held in the I_hi state
        clr();
        push(32'h0012_3400, 32'h0056_7800);
        wait_wr(1);
        out_full = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold", 32'(out_din), 32'(exp_b[0]));
        end
        chk("t3_nwr_held", n_wr, 1);
        out_full = 0;
        drain();
        chk("t3_nwr", n_wr, 4);

        // streaming 8 preloaded pairs
        clr();
        for (int i = 0; i < 8; i++) push(32'($urandom), 32'($urandom));
        drain();
        chk("t4_nwr", n_wr, 32);
        chk("t4_npop", n_pop, 8);
        chk("t4_span", last_wr - first_pop, 32);
        chk("t4_gap", gap_bad, 0);

        // unbalanced inputs
        clr();
        iq.push_back(32'h0000_0C00);
        repeat (10) step();
        chk("t5_nopop", n_pop, 0);
        qq.push_back(32'hFFFF_F400);
        step();
        chk("t5_pop", n_pop, 1);
        drain();

        // shift/clamp boundaries
        push(32'hFFFF_FFFF, 32'h0000_03FF);
        push(32'h01FF_FC00, 32'h0200_0000);
        push(32'hFE00_0000, 32'hFDFF_FC00);
        drain();

        // randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            logic [9:0] lo;
            r = 16'($urandom);
            lo = 10'($urandom);
            if ($urandom_range(0, 2) == 0) iq.push_back($urandom_range(0, 1) ? {{6{r[15]}}, r, lo} : 32'($urandom));
            r = 16'($urandom);
            lo = 10'($urandom);
            if ($urandom_range(0, 2) == 0) qq.push_back($urandom_range(0, 1) ? {{6{r[15]}}, r, lo} : 32'($urandom));
            out_full = $urandom_range(0, 3) == 0;
            step();
        end
        out_full = 0;
        drain();
        iq.delete();
        qq.delete();
        step();

        // async reset in the Q_lo state
        clr();
        push(32'h7FFF_FFFF, 32'h0001_0400);
        wait_wr(2);
        reset = 0;
        #1;
        chk("t6_wr", 32'(out_wr_en), 0);
        chk("t6_din", 32'(out_din), 0);
        chk("t6_rd", 32'(I_rd_en), 0);
        chk("t6_sat", 32'(sat_count), 0);
        exp_b.delete();
        exp_sat = 0;
        @(negedge clock);
        push(32'h0003_4400, 32'h0007_8800);
        repeat (2) step();
        reset = 1;
        clr();
        drain();
        chk("t6_nwr", n_wr, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
